// File: rtl/add_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  // A one-byte sequencer still needs a 1-bit index register.
  function automatic int idx_width(input int nbytes);
    return (nbytes <= 1) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/adder_8bit.sv
// Single-byte adder with carry in/out and signed overflow of the byte result.
module adder_8bit
  import add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_cin,
  output logic [BYTE_W-1:0] o_sum,
  output logic              o_carry,
  output logic              o_ovf
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{BYTE_W{1'b0}}, i_cin};

  // Overflow when both operands share a sign that the result does not.
  assign o_ovf = (i_a[BYTE_W-1] == i_b[BYTE_W-1]) && (o_sum[BYTE_W-1] != i_a[BYTE_W-1]);

endmodule

// File: rtl/add_byte_seq.sv
// Runs an N-byte add/subtract through one byte adder, LSB first, rippling the
// carry between cycles, with valid/ready handshakes on both sides.
module add_byte_seq
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [BYTE_W*NBYTES-1:0] i_a,
  input  logic [BYTE_W*NBYTES-1:0] i_b,
  input  logic                   i_sub,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [BYTE_W*NBYTES-1:0] o_sum,
  output logic                   o_carry,
  output logic                   o_ovf
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = idx_width(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  seq_state_t        state;
  seq_state_t        state_next;
  logic [IW-1:0]     idx;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic [W-1:0]      sum_r;
  logic              carry_r;
  logic              carry_flag;
  logic              ovf_flag;
  logic              valid_r;

  logic [BYTE_W-1:0] add_a;
  logic [BYTE_W-1:0] add_b;
  logic [BYTE_W-1:0] add_sum;
  logic              add_carry;
  logic              add_ovf;

  assign add_a = a_r[BYTE_W*idx +: BYTE_W];
  assign add_b = b_r[BYTE_W*idx +: BYTE_W];

  adder_8bit u_adder (
    .i_a     (add_a),
    .i_b     (add_b),
    .i_cin   (carry_r),
    .o_sum   (add_sum),
    .o_carry (add_carry),
    .o_ovf   (add_ovf)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_valid)          state_next = RUN;
      RUN:     if (idx == LAST_IDX)  state_next = DONE;
      DONE:    if (i_ready)          state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE) && !i_rst;
  end

  // Subtraction is a + ~b + 1: b is inverted at accept and the +1 enters as
  // the initial carry, so the byte adder never needs to know the operation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      idx        <= '0;
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      carry_r    <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_r     <= i_a;
            b_r     <= i_sub ? ~i_b : i_b;
            carry_r <= i_sub;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_r[BYTE_W*idx +: BYTE_W] <= add_sum;
          carry_r                     <= add_carry;
          if (idx == LAST_IDX) begin
            carry_flag <= add_carry;
            ovf_flag   <= add_ovf;
            valid_r    <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_valid = valid_r;
  assign o_sum   = sum_r;
  assign o_carry = carry_flag;
  assign o_ovf   = ovf_flag;

endmodule
